// File: rtl/fast_root_if.sv
// Start/ready handshake shared by the root and power units: operands in, result and ready out.
interface fast_root_if #(
  parameter int X = 16,
  parameter int N = 8
) ();
  logic         start;
  logic [X-1:0] inx;
  logic [N-1:0] inn;
  logic [X-1:0] out;
  logic         ready;

  modport master (output start, inx, inn, input out, ready);
  modport slave  (input start, inx, inn, output out, ready);
endinterface

// File: rtl/fast_root.sv
// Iterative integer n-th root: floor(inx^(1/inn)) by MSB-first binary search,
// each candidate raised to the power inn one multiply per cycle with early abort.
module fast_root #(
  parameter int X = 16,
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      nrst,
  fast_root_if.slave bus
);

  localparam int BW = $clog2(X);

  typedef enum logic [1:0] {READY, SETUP, MUL, NEXT} state_t;

  state_t         state, state_nxt;
  logic [X-1:0]   x, r, c, acc, out_q;
  logic [N-1:0]   n, cnt;
  logic [BW-1:0]  bit_idx;
  logic           over;
  logic [2*X-1:0] p;
  logic           too_big;

  // acc <= x holds before every multiply, so the full 2X-bit product never wraps.
  assign p       = {{X{1'b0}}, acc} * {{X{1'b0}}, c};
  assign too_big = (p[2*X-1:X] != '0) || (p[X-1:0] > x);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= READY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      READY: if (bus.start) state_nxt = SETUP;
      SETUP: state_nxt = (n == '0) ? READY : MUL;
      MUL:   if (too_big || cnt == N'(1)) state_nxt = NEXT;
      NEXT:  state_nxt = (bit_idx == '0) ? READY : SETUP;
      default: state_nxt = READY;
    endcase
  end

  always_comb begin
    bus.ready = (state == READY);
  end

  // NOTE: datapath registers are fully rewritten before use in every operation,
  // so they carry no reset; only the FSM state and the visible result are reset.
  always_ff @(posedge clk) begin
    case (state)
      READY: if (bus.start) begin
        x       <= bus.inx;
        n       <= bus.inn;
        r       <= '0;
        bit_idx <= BW'(X - 1);
      end
      SETUP: begin
        c    <= r | (X'(1) << bit_idx);
        acc  <= X'(1);
        cnt  <= n;
        over <= 1'b0;
      end
      MUL: begin
        if (too_big) begin
          over <= 1'b1;
        end else begin
          acc <= p[X-1:0];
          cnt <= cnt - N'(1);
        end
      end
      NEXT: begin
        if (!over)            r       <= c;
        if (bit_idx != '0)    bit_idx <= bit_idx - BW'(1);
      end
      default: ;
    endcase
  end

  // The result only moves on completion, so it stays stable while busy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q <= '0;
    end else if (state == SETUP && n == '0) begin
      out_q <= '0;
    end else if (state == NEXT && bit_idx == '0) begin
      out_q <= over ? r : c;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_fast_root.sv
// Self-checking bench for fast_root: scoreboard of expected roots, timing and protocol scenarios.
module tb_fast_root;

  localparam int X = 16;
  localparam int N = 8;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  fast_root_if #(.X(X), .N(N)) bus ();

  fast_root #(.X(X), .N(N)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned   chk_cnt  = 0;
  int unsigned   pass_cnt = 0;
  logic [X-1:0]  sb_q[$];
  int            last_busy;
  logic [X-1:0]  last_out;

  // Saturating power: any value above 65535 is reported as 65536.
  function automatic longint pw(longint b, int e);
    longint a = 1;
    for (int i = 0; i < e; i++) begin
      a = a * b;
      if (a > 65535) return 65536;
    end
    return a;
  endfunction

  function automatic logic [X-1:0] ref_root(longint x, int n);
    longint r = 0;
    if (n == 0) return '0;
    if (n == 1) return x[X-1:0];
    while (pw(r + 1, n) <= x) r++;
    return r[X-1:0];
  endfunction

  task automatic launch(input logic [X-1:0] x, input logic [N-1:0] n);
    int w = 0;
    while (bus.ready !== 1'b1 && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    bus.inx   = x;
    bus.inn   = n;
    bus.start = 1'b1;
    sb_q.push_back(ref_root(x, n));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic collect(input string name);
    logic [X-1:0] exp_v;
    logic [X-1:0] held;
    bit           moved = 1'b0;
    held      = bus.out;
    last_busy = 0;
    while (bus.ready !== 1'b1 && last_busy < LIMIT) begin
      last_busy++;
      @(negedge clk);
      if (bus.ready !== 1'b1 && bus.out !== held) moved = 1'b1;
    end
    chk_cnt++;
    if (last_busy >= LIMIT) begin
      $display("FAIL %s timeout: ready still %b after %0d cycles", name, bus.ready, last_busy);
      void'(sb_q.pop_front());
      return;
    end
    pass_cnt++;
    exp_v    = sb_q.pop_front();
    last_out = bus.out;
    chk_cnt++;
    if (bus.out !== exp_v) $display("FAIL %s out: got %0d expected %0d", name, bus.out, exp_v);
    else pass_cnt++;
    chk_cnt++;
    if (moved) $display("FAIL %s out_stable: out changed while busy (held %0d)", name, held);
    else pass_cnt++;
  endtask

  task automatic test_reset_state();
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.inx   = '0;
    bus.inn   = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (bus.ready !== 1'b1 || bus.out !== '0)
      $display("FAIL reset_state: ready=%b out=%0d expected ready=1 out=0", bus.ready, bus.out);
    else pass_cnt++;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cube();
    launch(16'd1000, 8'd3);
    collect("cube_1000");
    chk_cnt++;
    if (last_busy > 80) $display("FAIL cube_busy: got %0d cycles expected <= 80", last_busy);
    else pass_cnt++;
    launch(16'd999, 8'd3);
    collect("cube_999");
    chk_cnt++;
    if (last_busy > 80) $display("FAIL cube999_busy: got %0d cycles expected <= 80", last_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    launch(16'd1000, 8'd3);
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk_cnt++;
    if (bus.ready !== 1'b1 || bus.out !== '0)
      $display("FAIL reset_mid: ready=%b out=%0d expected ready=1 out=0", bus.ready, bus.out);
    else pass_cnt++;
    sb_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (bus.ready !== 1'b1 || bus.out !== '0)
      $display("FAIL reset_idle: ready=%b out=%0d expected ready=1 out=0", bus.ready, bus.out);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    launch(16'd65535, 8'd2);   collect("sqrt_max");
    launch(16'd65535, 8'd16);  collect("root16_max");
    launch(16'd65535, 8'd255); collect("root255_max");
    launch(16'd0, 8'd5);       collect("zero_radicand");
  endtask

  task automatic test_inn1();
    launch(16'd17, 8'd1);
    collect("inn1");
    chk_cnt++;
    if (last_busy !== 48) $display("FAIL inn1_busy: got %0d cycles expected 48", last_busy);
    else pass_cnt++;
  endtask

  task automatic test_inn0();
    launch(16'd100, 8'd2);
    collect("pre_inn0");
    launch(16'd1234, 8'd0);
    collect("inn0");
    chk_cnt++;
    if (last_busy !== 1) $display("FAIL inn0_busy: got %0d cycles expected 1", last_busy);
    else pass_cnt++;
  endtask

  task automatic test_protocol();
    launch(16'd1000, 8'd3);
    repeat (10) @(negedge clk);
    bus.inx   = 16'd5;
    bus.inn   = 8'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    collect("ignored_start");
  endtask

  task automatic test_back_to_back();
    launch(16'd1000, 8'd3);
    collect("b2b_first");
    // ready just rose: start asserted in the completion cycle itself
    launch(16'd81, 8'd4);
    chk_cnt++;
    if (bus.ready !== 1'b0) $display("FAIL b2b_accept: ready=%b expected 0", bus.ready);
    else pass_cnt++;
    collect("b2b_second");
  endtask

  task automatic test_random();
    logic [X-1:0] rx;
    int           rn;
    for (int i = 0; i < 40; i++) begin
      rx = X'($urandom_range(0, 65535));
      rn = $urandom_range(1, 8);
      launch(rx, N'(rn));
      collect("random");
      chk_cnt++;
      if (pw(longint'(last_out), rn) > longint'(rx) || pw(longint'(last_out) + 1, rn) <= longint'(rx))
        $display("FAIL random_bound: x=%0d n=%0d out=%0d not floor root", rx, rn, last_out);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset_state();
    test_cube();
    test_reset_mid();
    test_edges();
    test_inn1();
    test_inn0();
    test_protocol();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
